// File: rtl/fixed_mul_arbiter.sv
// Round-robin arbiter that shares one variable-latency signed multiplier among NREQ requesters.
// A watchdog aborts an operation whose multiplier never answers.
module fixed_mul_arbiter #(
  parameter int unsigned WIDTH   = 26,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_din1,
  input  logic [NREQ*WIDTH-1:0]   req_din2,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_dout,
  output logic                    rsp_err,
  output logic [WIDTH-1:0]        mul_din1,
  output logic [WIDTH-1:0]        mul_din2,
  output logic                    mul_din_valid,
  input  logic [2*WIDTH-1:0]      mul_dout,
  input  logic                    mul_dout_valid,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   pick;
  logic             found;
  logic             hs;
  logic [CW-1:0]    wdog;
  logic [WIDTH-1:0] sel_din1;
  logic [WIDTH-1:0] sel_din2;

  // First requesting lane at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && req_valid[(int'(ptr) + k) % int'(NREQ)]) begin
        found = 1'b1;
        pick  = IDW'((int'(ptr) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin
    sel_din1 = '0;
    sel_din2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick == IDW'(i)) begin
        sel_din1 = req_din1[i*WIDTH +: WIDTH];
        sel_din2 = req_din2[i*WIDTH +: WIDTH];
      end
    end
  end

  assign hs   = (state == StIdle) && found && !rst;
  assign busy = (state != StIdle);

  always_comb begin
    req_ready = '0;
    if (hs) req_ready = NREQ'(1) << pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      ptr           <= '0;
      grant_id      <= '0;
      err           <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_valid     <= '0;
      rsp_dout      <= '0;
      mul_din_valid <= 1'b0;
      mul_din1      <= '0;
      mul_din2      <= '0;
      wdog          <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (hs) begin
            mul_din1      <= sel_din1;
            mul_din2      <= sel_din2;
            grant_id      <= pick;
            ptr           <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
            mul_din_valid <= 1'b1;
            state         <= StIssue;
          end
        end
        StIssue: begin
          mul_din_valid <= 1'b0;
          wdog          <= '0;
          state         <= StWait;
        end
        StWait: begin
          // A strobe on the last watchdog cycle still counts as a good result.
          if (mul_dout_valid) begin
            rsp_dout  <= mul_dout;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= StResp;
          end else if (wdog == CW'(TIMEOUT - 1)) begin
            rsp_dout  <= '0;
            rsp_err   <= 1'b1;
            err       <= 1'b1;
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= StResp;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Bench for fixed_mul_arbiter: directed scenarios plus randomized traffic, with responses
// checked by a decoupled scoreboard monitor against a plain-arithmetic golden model.
module tb_fixed_mul_arbiter;

  localparam int WIDTH   = 26;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;
  localparam int PW      = 2 * WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_din1;
  logic [NREQ*WIDTH-1:0] req_din2;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [PW-1:0]         rsp_dout;
  logic                  rsp_err;
  logic [WIDTH-1:0]      mul_din1;
  logic [WIDTH-1:0]      mul_din2;
  logic                  mul_din_valid;
  logic [PW-1:0]         mul_dout;
  logic                  mul_dout_valid;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  err;

  fixed_mul_arbiter #(
    .WIDTH  (WIDTH),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_din1      (req_din1),
    .req_din2      (req_din2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_dout      (rsp_dout),
    .rsp_err       (rsp_err),
    .mul_din1      (mul_din1),
    .mul_din2      (mul_din2),
    .mul_din_valid (mul_din_valid),
    .mul_dout      (mul_dout),
    .mul_dout_valid(mul_dout_valid),
    .busy          (busy),
    .grant_id      (grant_id),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic [PW-1:0] dout;
    logic          e;
  } exp_t;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               mptr     = 0;
  int               waits[NREQ];
  logic [NREQ-1:0]  drop_mask = '0;
  logic [WIDTH-1:0] d1[NREQ];
  logic [WIDTH-1:0] d2[NREQ];

  int               mul_lat  = 4;
  bit               mul_hang = 1'b0;
  bit               stray    = 1'b0;
  int               mcnt     = 0;
  logic [PW-1:0]    mprod;

  bit               mon_hold = 1'b0;
  logic [NREQ-1:0]  mon_v;
  logic [PW-1:0]    mon_d;

  function automatic logic [PW-1:0] gold(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    return p[PW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = {1'b1, {(WIDTH-1){1'b0}}};
      1:       v = {1'b0, {(WIDTH-1){1'b1}}};
      2:       v = '1;
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
    cyc++;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_pack();
    for (int i = 0; i < NREQ; i++) begin
      req_din1[i*WIDTH +: WIDTH] = d1[i];
      req_din2[i*WIDTH +: WIDTH] = d2[i];
    end
  endtask

  // Detects a request handshake, checks the grant against round-robin rules, queues the expectation.
  task automatic observe(output int g);
    int   exp_g;
    exp_t e;
    g     = -1;
    exp_g = -1;
    check("req_ready_only_valid", 64'(req_ready & ~req_valid), 64'd0);
    if ((req_valid & req_ready) != '0) begin
      for (int k = 0; k < NREQ; k++)
        if (exp_g < 0 && req_valid[(mptr + k) % NREQ]) exp_g = (mptr + k) % NREQ;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) g = i;
      check("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
      check("grant_lane", 64'(g), 64'(exp_g));
      check("fair_wait", 64'(waits[g] < NREQ), 64'd1);
      e.lane = g;
      e.e    = mul_hang;
      e.dout = mul_hang ? '0 : gold(d1[g], d2[g]);
      exp_q.push_back(e);
      for (int i = 0; i < NREQ; i++)
        if (i != g && req_valid[i]) waits[i]++;
      waits[g]     = 0;
      mptr         = (g + 1) % NREQ;
      drop_mask[g] = 1'b1;
    end
  endtask

  task automatic model_reset();
    mptr      = 0;
    drop_mask = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) waits[i] = 0;
  endtask

  task automatic do_reset();
    to_drive();
    rst       = 1'b1;
    req_valid = '0;
    to_sample();
    model_reset();
    to_drive();
    rst = 1'b0;
    to_sample();
  endtask

  task automatic do_op(input int lane, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int t);
    int g;
    bit done;
    done     = 1'b0;
    t        = -1;
    d1[lane] = a;
    d2[lane] = b;
    for (int n = 0; n < 40 && !done; n++) begin
      to_drive();
      req_valid[lane] = 1'b1;
      drive_pack();
      to_sample();
      observe(g);
      if (g == lane) begin
        done = 1'b1;
        t    = cyc;
      end
    end
    check("op_granted", 64'(done), 64'd1);
  endtask

  task automatic run_until_idle(input int limit);
    int g;
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0 || busy) && n < limit) begin
      to_drive();
      rsp_ready = '1;
      to_sample();
      observe(g);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Stand-in for fixed_mul_nb: answers mul_lat cycles after the start pulse, or never when hung.
  initial begin : mul_model
    mul_dout_valid = 1'b0;
    mul_dout       = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_dout_valid = 1'b0;
      if (rst) begin
        mcnt = 0;
      end else begin
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            mul_dout_valid = 1'b1;
            mul_dout       = mprod;
          end
        end
        if (mul_din_valid) begin
          mprod = gold(mul_din1, mul_din2);
          mcnt  = mul_hang ? 0 : mul_lat;
        end
      end
      if (stray) begin
        mul_dout_valid = 1'b1;
        mul_dout       = PW'($urandom);
        stray          = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_hold = 1'b0;
      end else if (rsp_valid != '0) begin
        if (mon_hold) begin
          check("rsp_hold_valid", 64'(rsp_valid), 64'(mon_v));
          check("rsp_hold_dout", 64'(rsp_dout), 64'(mon_d));
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b, expected no response", rsp_valid);
          end else begin
            e = exp_q.pop_front();
            check("rsp_lane", 64'(rsp_valid), 64'(1 << e.lane));
            check("rsp_dout", 64'(rsp_dout), 64'(e.dout));
            check("rsp_err", 64'(rsp_err), 64'(e.e));
          end
          mon_hold = 1'b0;
        end else begin
          mon_hold = 1'b1;
          mon_v    = rsp_valid;
          mon_d    = rsp_dout;
        end
      end else begin
        mon_hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int               t, g, ops, n;
    int               gc[NREQ];
    logic [WIDTH-1:0] m5, mn;
    m5        = WIDTH'(-5);
    mn        = {1'b1, {(WIDTH-1){1'b0}}};
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      d1[i]    = '0;
      d2[i]    = '0;
      waits[i] = 0;
    end
    drive_pack();

    // Reset values, with every lane requesting while rst is high.
    to_drive();
    req_valid = '1;
    to_sample();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    to_drive();
    to_sample();
    check("rst_req_ready2", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mul_din_valid", 64'(mul_din_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_dout", 64'(rsp_dout), 64'd0);
    check("rst_mul_din1", 64'(mul_din1), 64'd0);
    check("rst_mul_din2", 64'(mul_din2), 64'd0);
    to_drive();
    rst       = 1'b0;
    req_valid = '0;
    to_sample();

    // Single operation on lane 2, latency 4.
    rsp_ready = '1;
    mul_lat   = 4;
    do_op(2, WIDTH'(3), m5, t);
    for (int k = 1; k <= 7; k++) begin
      to_drive();
      to_sample();
      check("t1_mul_din_valid", 64'(mul_din_valid), 64'(k == 1));
      check("t1_rsp_valid", 64'(rsp_valid), (k == 6) ? 64'h4 : 64'h0);
      check("t1_busy", 64'(busy), 64'(k <= 6));
      if (k == 1) begin
        check("t1_mul_din1", 64'(mul_din1), 64'd3);
        check("t1_mul_din2", 64'(mul_din2), 64'(m5));
        check("t1_grant_id", 64'(grant_id), 64'd2);
      end
      if (k == 6) begin
        check("t1_rsp_dout", 64'(rsp_dout), 64'(52'hFFFFFFFFFFFF1));
        check("t1_rsp_err", 64'(rsp_err), 64'd0);
      end
    end

    // All lanes request together from reset: grants 0,1,2,3 spaced L+3 apart.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      d1[i] = rand_op();
      d2[i] = rand_op();
    end
    n = 0;
    to_drive();
    req_valid = '1;
    drive_pack();
    to_sample();
    for (int c = 0; c < 60 && n < NREQ; c++) begin
      observe(g);
      if (g >= 0) begin
        check("t2_order", 64'(g), 64'(n));
        gc[n] = cyc;
        n++;
      end
      if (n < NREQ) begin
        to_drive();
        to_sample();
      end
    end
    check("t2_all_granted", 64'(n), 64'(NREQ));
    for (int i = 1; i < n; i++) check("t2_spacing", 64'(gc[i] - gc[i-1]), 64'(mul_lat + 3));
    run_until_idle(100);

    // Extreme operands with the response held off for 10 cycles; other lanes' ready ignored.
    do_op(0, mn, mn, t);
    for (int c = 0; c < 30 && rsp_valid == '0; c++) begin
      to_drive();
      rsp_ready = 4'b1110;
      to_sample();
    end
    check("t3_rsp_seen", 64'(rsp_valid != '0), 64'd1);
    for (int j = 0; j < 10; j++) begin
      check("t3_hold_valid", 64'(rsp_valid), 64'd1);
      check("t3_hold_dout", 64'(rsp_dout), 64'd1125899906842624);
      to_drive();
      rsp_ready = (j == 9) ? 4'b0001 : 4'b1110;
      to_sample();
    end
    to_drive();
    rsp_ready = '1;
    to_sample();
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Hung multiplier: abort after TIMEOUT cycles in WAIT.
    mul_hang = 1'b1;
    do_op(1, rand_op(), rand_op(), t);
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      to_drive();
      to_sample();
      check("t4_rsp_valid", 64'(rsp_valid), (k == TIMEOUT + 2) ? 64'h2 : 64'h0);
      check("t4_err", 64'(err), 64'(k >= TIMEOUT + 2));
    end
    mul_hang = 1'b0;
    mul_lat  = 3;
    do_op(3, rand_op(), rand_op(), t);
    run_until_idle(100);
    check("t4_err_sticky", 64'(err), 64'd1);
    // Strobe on the final watchdog cycle wins over the abort.
    mul_lat = TIMEOUT;
    do_op(2, rand_op(), rand_op(), t);
    run_until_idle(200);

    // Reset during WAIT followed by a stray strobe.
    mul_hang = 1'b1;
    do_op(2, rand_op(), rand_op(), t);
    to_drive();
    to_sample();
    to_drive();
    to_sample();
    to_drive();
    rst = 1'b1;
    to_sample();
    model_reset();
    to_drive();
    rst   = 1'b0;
    stray = 1'b1;
    to_sample();
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_err", 64'(err), 64'd0);
    check("t5_rsp_err", 64'(rsp_err), 64'd0);
    check("t5_grant_id", 64'(grant_id), 64'd0);
    check("t5_mul_din_valid", 64'(mul_din_valid), 64'd0);
    check("t5_mul_din1", 64'(mul_din1), 64'd0);
    check("t5_rsp_dout", 64'(rsp_dout), 64'd0);
    for (int k = 0; k < 4; k++) begin
      to_drive();
      to_sample();
      check("t5_stay_idle", 64'(busy), 64'd0);
      check("t5_no_rsp", 64'(rsp_valid), 64'd0);
    end
    mul_hang = 1'b0;
    mul_lat  = 2;
    d1[0] = rand_op();
    d2[0] = rand_op();
    d1[3] = rand_op();
    d2[3] = rand_op();
    to_drive();
    req_valid = 4'b1001;
    drive_pack();
    to_sample();
    observe(g);
    check("t5_ptr_reset_grant", 64'(g), 64'd0);
    run_until_idle(100);

    // Randomized traffic: requests held until granted, random backpressure and latency.
    ops = 0;
    for (int c = 0; c < 40000 && ops < 1000; c++) begin
      to_drive();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          d1[i]        = rand_op();
          d2[i]        = rand_op();
          req_valid[i] = 1'b1;
        end
      end
      drive_pack();
      rsp_ready = NREQ'($urandom);
      mul_lat   = $urandom_range(1, 20);
      to_sample();
      observe(g);
      if (g >= 0) ops++;
    end
    check("t6_ops_done", 64'(ops >= 1000), 64'd1);
    run_until_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
